// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, keyboard command bytes and a parity helper.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRelease,
      StWaitFirst,
      StSend,
      StWaitAck,
      StWaitIdle,
      StErr
   } tx_state_e;

   localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
   localparam logic [7:0] PS2_ACK        = 8'hFA;
   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_EXT        = 8'hE0;

   // Odd parity: total count of ones across data and parity bit is odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus FILTER_LEN-sample debounce for one PS/2 line, with a falling-edge pulse.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_q;
   logic          level_q;
   logic          fall_q;
   logic [CW-1:0] cnt_q;

   // Idle PS/2 lines float high, so the filter starts at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q <= {sync_q[0], line_in};
         fall_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_q <= sync_q[1];
            fall_q  <= level_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start bit, 8 data + odd parity + stop, then ACK check.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC   = 2500,
   parameter int unsigned START_TIMEOUT = 375000,
   parameter int unsigned FRAME_TIMEOUT = 50000,
   parameter int unsigned FILTER_LEN    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_c_in,
   input  logic       ps2_d_in,
   output logic       ps2_c_oe,
   output logic       ps2_d_oe
);

   localparam int unsigned MAX_AB  = (INHIBIT_CYC > START_TIMEOUT) ? INHIBIT_CYC : START_TIMEOUT;
   localparam int unsigned MAX_CYC = (MAX_AB > FRAME_TIMEOUT) ? MAX_AB : FRAME_TIMEOUT;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);

   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [9:0]    shreg_q, shreg_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic          d_oe_q, d_oe_d;
   logic          done_q, done_d;
   logic [1:0]    d_sync_q;
   logic          c_level, c_fall;
   logic          frame_to;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_c_filter (
      .clk    (clk),
      .rst    (rst),
      .line_in(ps2_c_in),
      .level  (c_level),
      .fall   (c_fall)
   );

   assign cnt_inc  = (cnt_q == CW'(MAX_CYC)) ? cnt_q : cnt_q + 1'b1;
   assign frame_to = (cnt_q == CW'(FRAME_TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      d_oe_d   = d_oe_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               shreg_d  = {1'b1, odd_parity(tx_data), tx_data};
               bitcnt_d = '0;
               cnt_d    = '0;
               state_d  = StInhibit;
            end
         end
         StInhibit: begin
            if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
               d_oe_d  = 1'b1;
               cnt_d   = '0;
               state_d = StRelease;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StRelease: begin
            cnt_d   = '0;
            state_d = StWaitFirst;
         end
         StWaitFirst: begin
            if (c_fall) begin
               d_oe_d  = ~shreg_q[0];
               cnt_d   = '0;
               state_d = StSend;
            end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
               state_d = StErr;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StSend: begin
            cnt_d = cnt_inc;
            if (c_fall) begin
               // Shift so shreg_q[0] is always the bit currently on the line.
               shreg_d  = {1'b1, shreg_q[9:1]};
               d_oe_d   = ~shreg_q[1];
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q == 4'd8) state_d = StWaitAck;
            end else if (frame_to) begin
               state_d = StErr;
            end
         end
         StWaitAck: begin
            cnt_d = cnt_inc;
            if (c_fall) begin
               state_d = d_sync_q[1] ? StErr : StWaitIdle;
            end else if (frame_to) begin
               state_d = StErr;
            end
         end
         StWaitIdle: begin
            cnt_d = cnt_inc;
            if (c_level && d_sync_q[1]) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (frame_to) begin
               state_d = StErr;
            end
         end
         StErr: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (state_d == StErr || state_d == StIdle) d_oe_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         shreg_q  <= '1;
         bitcnt_q <= '0;
         d_oe_q   <= 1'b0;
         done_q   <= 1'b0;
         d_sync_q <= 2'b11;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         d_oe_q   <= d_oe_d;
         done_q   <= done_d;
         d_sync_q <= {d_sync_q[0], ps2_d_in};
      end
   end

   assign tx_ready = (state_q == StIdle);
   assign tx_busy  = (state_q != StIdle);
   assign tx_done  = done_q;
   assign tx_err   = (state_q == StErr);
   assign ps2_c_oe = (state_q == StInhibit);
   assign ps2_d_oe = d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model with a behavioural PS/2 device.
module tb_ps2_host_tx;

   localparam int unsigned INH = 100;
   localparam int unsigned STO = 1500;
   localparam int unsigned FTO = 2000;
   localparam int unsigned FLT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_busy, tx_done, tx_err;
   logic       ps2_c_in, ps2_d_in, ps2_c_oe, ps2_d_oe;
   logic       dev_c_low = 1'b0;
   logic       dev_d_low = 1'b0;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   assign ps2_c_in = ~(ps2_c_oe | dev_c_low);
   assign ps2_d_in = ~(ps2_d_oe | dev_d_low);

   ps2_host_tx #(
      .INHIBIT_CYC  (INH),
      .START_TIMEOUT(STO),
      .FRAME_TIMEOUT(FTO),
      .FILTER_LEN   (FLT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .tx_busy (tx_busy),
      .tx_done (tx_done),
      .tx_err  (tx_err),
      .ps2_c_in(ps2_c_in),
      .ps2_d_in(ps2_d_in),
      .ps2_c_oe(ps2_c_oe),
      .ps2_d_oe(ps2_d_oe)
   );

   always #20 clk = ~clk;

   initial begin
      #10_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_done) done_cnt++;
         if (tx_err) err_cnt++;
         if (tx_done || tx_err) check("pulse_exclusive", 32'(tx_done & tx_err), 0);
         if (tx_done) check("busy_low_with_done", 32'(tx_busy), 0);
      end
   end

   // Expected wire order as the device sees it: d0..d7, odd parity, stop.
   function automatic logic [9:0] exp_frame(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
   endfunction

   task automatic offer(input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      while (!tx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 0, 1);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // mode 0: normal, 1: reset after 4th fall, 2: clock glitch + tx_valid while busy
   task automatic device(input bit ack, input int half, input int mode, output logic [9:0] rx);
      int n;
      rx = '1;
      n = 0;
      while (!ps2_c_oe && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (ps2_c_oe && n < int'(INH) * 4) begin
         @(negedge clk);
         n++;
      end
      check("inhibit_len", 32'(n), INH);
      check("start_bit_oe", 32'(ps2_d_oe), 1);
      repeat (10) @(negedge clk);
      check("start_bit_line", 32'(ps2_d_in), 0);
      for (int i = 0; i < 10; i++) begin
         dev_c_low = 1'b1;
         repeat (half) @(negedge clk);
         if (mode == 1 && i == 3) begin
            check("d3_driven_before_rst", 32'(ps2_d_oe), 1);
            rst = 1'b1;
            @(negedge clk);
            check("rst_c_oe", 32'(ps2_c_oe), 0);
            check("rst_d_oe", 32'(ps2_d_oe), 0);
            check("rst_ready", 32'(tx_ready), 1);
            check("rst_pulses", 32'({tx_done, tx_err}), 0);
            rst = 1'b0;
            dev_c_low = 1'b0;
            return;
         end
         dev_c_low = 1'b0;
         rx[i] = ps2_d_in;
         if (mode == 2 && i == 4) begin
            repeat (4) @(negedge clk);
            dev_c_low = 1'b1;
            tx_valid  = 1'b1;
            tx_data   = 8'h55;
            repeat (3) @(negedge clk);
            dev_c_low = 1'b0;
            tx_valid  = 1'b0;
            repeat (half - 7) @(negedge clk);
         end else begin
            repeat (half) @(negedge clk);
         end
      end
      check("stop_released", 32'(ps2_d_oe), 0);
      if (ack) dev_d_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_c_low = 1'b1;
      repeat (half) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (half) @(negedge clk);
      dev_d_low = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] d, input bit ack, input int half, input int mode,
                            output logic [9:0] rx, output int got_done, output int got_err);
      int d0 = done_cnt;
      int e0 = err_cnt;
      int n = 0;
      offer(d);
      device(ack, half, mode, rx);
      while (done_cnt == d0 && err_cnt == e0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("result_timeout", 0, 1);
      repeat (5) @(negedge clk);
      got_done = done_cnt - d0;
      got_err  = err_cnt - e0;
   endtask

   typedef struct {
      logic [7:0] data;
      bit         ack;
      int         half;
   } vec_t;

   initial begin
      vec_t       vecs[4];
      logic [9:0] rx;
      int         gd, ge, n, seen, d0, e0;
      logic [7:0] rd;
      bit         rack;

      vecs[0] = '{8'hED, 1'b1, 20};
      vecs[1] = '{8'hF4, 1'b1, 25};
      vecs[2] = '{8'hFF, 1'b0, 20};
      vecs[3] = '{8'h00, 1'b1, 16};

      repeat (5) @(negedge clk);
      check("reset_ready", 32'(tx_ready), 1);
      check("reset_busy", 32'(tx_busy), 0);
      check("reset_pulses", 32'({tx_done, tx_err}), 0);
      check("reset_lines", 32'({ps2_c_oe, ps2_d_oe}), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         run_frame(vecs[v].data, vecs[v].ack, vecs[v].half, 0, rx, gd, ge);
         check($sformatf("vec%0d_bits", v), 32'(rx), 32'(exp_frame(vecs[v].data)));
         check($sformatf("vec%0d_done", v), 32'(gd), vecs[v].ack ? 1 : 0);
         check($sformatf("vec%0d_err", v), 32'(ge), vecs[v].ack ? 0 : 1);
         check($sformatf("vec%0d_idle", v), 32'(tx_ready), 1);
      end

      // Device never clocks: WAIT_FIRST lasts START_TIMEOUT cycles, then the ERR cycle.
      offer(8'h12);
      n = 0;
      while (!ps2_c_oe && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (ps2_c_oe && n < int'(INH) * 4) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!tx_err && n < int'(STO) + 100) begin
         @(negedge clk);
         n++;
      end
      check("start_timeout_cycles", 32'(n), STO + 1);
      check("timeout_lines", 32'({ps2_c_oe, ps2_d_oe}), 0);
      repeat (5) @(negedge clk);
      check("timeout_idle", 32'(tx_ready), 1);

      // Reset mid-frame, then a clean resend.
      d0 = done_cnt;
      e0 = err_cnt;
      offer(8'hA5);
      device(1'b1, 20, 1, rx);
      repeat (200) @(negedge clk);
      check("rst_no_done", 32'(done_cnt - d0), 0);
      check("rst_no_err", 32'(err_cnt - e0), 0);
      check("rst_not_busy", 32'(tx_busy), 0);
      run_frame(8'hFF, 1'b1, 20, 0, rx, gd, ge);
      check("after_rst_bits", 32'(rx), 32'(exp_frame(8'hFF)));
      check("after_rst_done", 32'(gd), 1);

      // Clock glitch and a byte offered while busy.
      run_frame(8'h3C, 1'b1, 20, 2, rx, gd, ge);
      check("glitch_bits", 32'(rx), 32'(exp_frame(8'h3C)));
      check("glitch_done", 32'(gd), 1);
      check("glitch_err", 32'(ge), 0);
      seen = 0;
      repeat (INH * 3) begin
         @(negedge clk);
         if (ps2_c_oe || tx_busy) seen = 1;
      end
      check("busy_byte_dropped", 32'(seen), 0);

      for (int r = 0; r < 12; r++) begin
         rd   = 8'($urandom);
         rack = ($urandom_range(0, 3) != 0);
         run_frame(rd, rack, $urandom_range(16, 30), 0, rx, gd, ge);
         check($sformatf("rnd%0d_bits_%02h", r, rd), 32'(rx), 32'(exp_frame(rd)));
         check($sformatf("rnd%0d_done", r), 32'(gd), rack ? 1 : 0);
         check($sformatf("rnd%0d_err", r), 32'(ge), rack ? 0 : 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
